jam_cost_table: RTL

- Upstream stage of the job-assignment enumerator.
- Accepts the 8x8 worker/job cost matrix as a valid/ready stream and stores it in a flop array.
- Serves zero-latency combinational Cost lookups on the enumerator's W/J indices.
- Holds the enumerator in reset until the table is complete, and computes a lower bound (sum of per-worker row minima) during load.

---
 rtl/jam_cost_table_if.sv | 21 ++
 rtl/jam_cost_table.sv | 126 ++++++++++++
 2 files changed

// File: rtl/jam_cost_table_if.sv
// Cost-entry stream into the job-assignment cost table.
// The master is the cost source. The slave is the table.
interface jam_cost_table_if #(
    parameter int COST_W = 7
);
    logic              in_valid;
    logic [COST_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/jam_cost_table.sv
// jam_cost_table: loads an NxN worker/job cost matrix from a valid/ready
// stream into flops. It serves combinational Cost lookups on the enumerator's
// W/J indices. It holds the enumerator in reset until the table is complete.
// While the table loads, it accumulates the sum of the per-worker row minima
// as a lower bound on any assignment cost.
module jam_cost_table #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic               CLK,
    input  logic               RSTn,
    jam_cost_table_if.slave    in_if,
    input  logic               reload,
    input  logic [IDX_W-1:0]   W,
    input  logic [IDX_W-1:0]   J,
    output logic [COST_W-1:0]  Cost,
    output logic               table_ready,
    output logic               jam_rst,
    output logic [6:0]         in_count,
    output logic [9:0]         lower_bound
);

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    localparam logic [6:0] LAST_ENTRY = 7'(N * N - 1);
    localparam logic [6:0] FULL_COUNT = 7'(N * N);

    logic [0:0]        state_q, state_d;
    logic [6:0]        in_count_q, in_count_d;
    logic              table_ready_q, table_ready_d;
    logic [9:0]        lower_bound_q, lower_bound_d;
    logic [9:0]        acc_q, acc_d;
    logic [COST_W-1:0] row_min_q, row_min_d;
    logic [COST_W-1:0] table_q [N][N];
    logic [COST_W-1:0] table_d [N][N];

    logic              accept;
    logic [IDX_W-1:0]  wr_row;
    logic [IDX_W-1:0]  wr_col;
    logic [COST_W-1:0] min_val;

    assign in_if.in_ready = (state_q == LOAD);
    assign accept         = in_if.in_valid && (state_q == LOAD);
    assign wr_row         = in_count_q[2*IDX_W-1:IDX_W];
    assign wr_col         = in_count_q[IDX_W-1:0];
    assign min_val        = (in_if.in_data < row_min_q) ? in_if.in_data : row_min_q;

    // Next-state logic. Reload takes priority over an accept, so any entry
    // offered in the reload cycle is dropped. Table contents survive a reload.
    always_comb begin
        state_d       = state_q;
        in_count_d    = in_count_q;
        table_ready_d = table_ready_q;
        lower_bound_d = lower_bound_q;
        acc_d         = acc_q;
        row_min_d     = row_min_q;
        table_d       = table_q;

        if (reload) begin
            state_d       = LOAD;
            in_count_d    = 7'd0;
            table_ready_d = 1'b0;
            acc_d         = 10'd0;
            lower_bound_d = 10'd0;
        end else if (accept) begin
            table_d[wr_row][wr_col] = in_if.in_data;
            in_count_d              = in_count_q + 7'd1;

            if (wr_col == '0) begin
                row_min_d = in_if.in_data;
            end else if (wr_col == IDX_W'(N - 1)) begin
                acc_d = acc_q + 10'(min_val);
            end else begin
                row_min_d = min_val;
            end

            if (in_count_q == LAST_ENTRY) begin
                state_d       = DONE;
                in_count_d    = FULL_COUNT;
                table_ready_d = 1'b1;
                lower_bound_d = acc_q + 10'(min_val);
            end
        end
    end

    // State and table registers. All of them reset asynchronously, so a partial load is discarded at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= LOAD;
            in_count_q    <= 7'd0;
            table_ready_q <= 1'b0;
            lower_bound_q <= 10'd0;
            acc_q         <= 10'd0;
            row_min_q     <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    table_q[r][c] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            in_count_q    <= in_count_d;
            table_ready_q <= table_ready_d;
            lower_bound_q <= lower_bound_d;
            acc_q         <= acc_d;
            row_min_q     <= row_min_d;
            table_q       <= table_d;
        end
    end

    // Zero-latency lookup. The enumerator samples Cost one edge after it registers W/J, so Cost has no output register.
    always_comb begin
        Cost = '0;
        if (table_ready_q) begin
            Cost = table_q[W][J];
        end
    end

    assign table_ready = table_ready_q;
    assign jam_rst     = ~table_ready_q;
    assign in_count    = in_count_q;
    assign lower_bound = lower_bound_q;

endmodule
